// File: rtl/regfile_read_stage_pkg.sv
// Shared types for the issue-to-execute operand read stage.
// Physical register file geometry, issue payload, FU option code and bypass record.
package regfile_read_stage_pkg;

    localparam int unsigned PHY_REG_NUM   = 64;
    localparam int unsigned PREG_AW       = $clog2(PHY_REG_NUM);
    localparam int unsigned WB_WIDTH      = 2;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned ROB_AW        = 5;

    typedef struct packed {
        logic [ROB_AW-1:0]  rob_idx;
        logic               psrc0_valid;
        logic [PREG_AW-1:0] psrc0;
        logic               psrc1_valid;
        logic [PREG_AW-1:0] psrc1;
        logic               pdest_valid;
        logic [PREG_AW-1:0] pdest;
    } IssueBaseSt;

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSlt
    } AluOpE;

    typedef struct packed {
        AluOpE       op;
        logic        imm_sel;
        logic [11:0] imm;
    } OptionCodeSt;

    typedef struct packed {
        logic                     hit;
        logic [RF_DATA_WIDTH-1:0] data;
    } OperandBypassSt;

endpackage

// File: rtl/regfile_read_lane.sv
// One lane of the operand read pipeline: S1 drives regfile addresses and snoops
// write-back, S2 merges the synchronous read data with the bypass and holds under backpressure.
module regfile_read_lane
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = RF_DATA_WIDTH,
    parameter type         OPTION_CODE = OptionCodeSt
) (
    input  logic                               clk,
    input  logic                               a_rst_n,
    input  logic                               flush_i,
    input  logic                               issue_valid_i,
    output logic                               issue_ready_o,
    input  IssueBaseSt                         issue_base_i,
    input  OPTION_CODE                         issue_oc_i,
    output logic [1:0][PREG_AW-1:0]            rf_raddr_o,
    input  logic [1:0][DATA_WIDTH-1:0]         rf_rdata_i,
    input  logic [WB_WIDTH-1:0]                wb_i,
    input  logic [WB_WIDTH-1:0][PREG_AW-1:0]   wb_pdest_i,
    input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0] wb_data_i,
    output logic                               exe_valid_o,
    input  logic                               exe_ready_i,
    output IssueBaseSt                         exe_base_o,
    output OPTION_CODE                         exe_oc_o,
    output logic [DATA_WIDTH-1:0]              exe_src0_o,
    output logic [DATA_WIDTH-1:0]              exe_src1_o
);

    logic                         r_s1_valid;
    IssueBaseSt                   r_s1_base;
    OPTION_CODE                   r_s1_oc;
    OperandBypassSt [1:0]         r_s1_byp;
    logic [1:0][PREG_AW-1:0]      r_raddr;

    logic                         r_s2_valid;
    logic                         r_s2_fresh;
    IssueBaseSt                   r_s2_base;
    OPTION_CODE                   r_s2_oc;
    OperandBypassSt [1:0]         r_s2_byp;
    logic [1:0][DATA_WIDTH-1:0]   r_src;

    logic                         w_s2_adv;
    logic                         w_s1_adv;
    logic                         w_accept;
    logic                         w_s1_to_s2;
    logic [1:0]                   w_psrc_valid;
    logic [1:0][PREG_AW-1:0]      w_psrc;
    logic [1:0]                   w_s2_psrc_valid;
    OperandBypassSt [1:0]         w_s1_byp_next;
    logic [1:0][DATA_WIDTH-1:0]   w_src;

    assign w_s2_adv      = ~r_s2_valid | exe_ready_i;
    assign w_s1_adv      = ~r_s1_valid | w_s2_adv;
    assign issue_ready_o = w_s1_adv & ~flush_i;
    assign w_accept      = issue_valid_i & issue_ready_o;
    assign w_s1_to_s2    = r_s1_valid & w_s2_adv;

    assign w_psrc_valid    = {r_s1_base.psrc1_valid, r_s1_base.psrc0_valid};
    assign w_psrc          = {r_s1_base.psrc1, r_s1_base.psrc0};
    assign w_s2_psrc_valid = {r_s2_base.psrc1_valid, r_s2_base.psrc0_valid};

    // Descending scan so the lowest matching write-back port is the one that sticks.
    always_comb begin
        w_s1_byp_next = r_s1_byp;
        for (int n = 0; n < 2; n++) begin
            for (int k = int'(WB_WIDTH) - 1; k >= 0; k--) begin
                if (w_psrc_valid[n] && wb_i[k] && (wb_pdest_i[k] == w_psrc[n])) begin
                    w_s1_byp_next[n].hit  = 1'b1;
                    w_s1_byp_next[n].data = wb_data_i[k];
                end
            end
        end
    end

    always_comb begin
        w_src = '0;
        for (int n = 0; n < 2; n++) begin
            if (!w_s2_psrc_valid[n]) begin
                w_src[n] = '0;
            end else if (r_s2_fresh) begin
                w_src[n] = r_s2_byp[n].hit ? r_s2_byp[n].data : rf_rdata_i[n];
            end else begin
                w_src[n] = r_src[n];
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_base  <= '0;
            r_s1_oc    <= '0;
            r_s1_byp   <= '0;
            r_raddr    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_fresh <= 1'b0;
            r_s2_base  <= '0;
            r_s2_oc    <= '0;
            r_s2_byp   <= '0;
            r_src      <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_fresh <= 1'b0;
            r_s1_byp   <= '0;
            r_s2_byp   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_base  <= issue_base_i;
                r_s1_oc    <= issue_oc_i;
                r_raddr    <= {issue_base_i.psrc1, issue_base_i.psrc0};
                r_s1_byp   <= '0;
            end else begin
                if (w_s1_to_s2) r_s1_valid <= 1'b0;
                if (r_s1_valid) r_s1_byp <= w_s1_byp_next;
            end

            if (w_s1_to_s2) begin
                r_s2_valid <= 1'b1;
                r_s2_fresh <= 1'b1;
                r_s2_base  <= r_s1_base;
                r_s2_oc    <= r_s1_oc;
                r_s2_byp   <= w_s1_byp_next;
            end else begin
                if (w_s2_adv) r_s2_valid <= 1'b0;
                // Read data is only valid in the first S2 cycle; freeze it for stalls.
                if (r_s2_fresh) begin
                    r_s2_fresh <= 1'b0;
                    r_src      <= w_src;
                end
            end
        end
    end

    assign rf_raddr_o  = r_raddr;
    assign exe_valid_o = r_s2_valid & ~flush_i;
    assign exe_base_o  = r_s2_base;
    assign exe_oc_o    = r_s2_oc;
    assign exe_src0_o  = w_src[0];
    assign exe_src1_o  = w_src[1];

endmodule

// File: rtl/regfile_read_stage.sv
// Operand read boundary of the backend: one independent S1/S2 lane per RS bank.
// Write-back snoop buses are shared by every lane.
module regfile_read_stage
    import regfile_read_stage_pkg::*;
#(
    parameter int unsigned BANK_NUM    = 2,
    parameter int unsigned DATA_WIDTH  = RF_DATA_WIDTH,
    parameter type         OPTION_CODE = OptionCodeSt
) (
    input  logic                                      clk,
    input  logic                                      a_rst_n,
    input  logic                                      flush_i,
    input  logic [BANK_NUM-1:0]                       issue_valid_i,
    output logic [BANK_NUM-1:0]                       issue_ready_o,
    input  IssueBaseSt [BANK_NUM-1:0]                 issue_base_i,
    input  OPTION_CODE [BANK_NUM-1:0]                 issue_oc_i,
    output logic [BANK_NUM-1:0][1:0][PREG_AW-1:0]     rf_raddr_o,
    input  logic [BANK_NUM-1:0][1:0][DATA_WIDTH-1:0]  rf_rdata_i,
    input  logic [WB_WIDTH-1:0]                       wb_i,
    input  logic [WB_WIDTH-1:0][PREG_AW-1:0]          wb_pdest_i,
    input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0]       wb_data_i,
    output logic [BANK_NUM-1:0]                       exe_valid_o,
    input  logic [BANK_NUM-1:0]                       exe_ready_i,
    output IssueBaseSt [BANK_NUM-1:0]                 exe_base_o,
    output OPTION_CODE [BANK_NUM-1:0]                 exe_oc_o,
    output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]       exe_src0_o,
    output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]       exe_src1_o
);

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_lane
        regfile_read_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .OPTION_CODE (OPTION_CODE)
        ) u_lane (
            .clk           (clk),
            .a_rst_n       (a_rst_n),
            .flush_i       (flush_i),
            .issue_valid_i (issue_valid_i[b]),
            .issue_ready_o (issue_ready_o[b]),
            .issue_base_i  (issue_base_i[b]),
            .issue_oc_i    (issue_oc_i[b]),
            .rf_raddr_o    (rf_raddr_o[b]),
            .rf_rdata_i    (rf_rdata_i[b]),
            .wb_i          (wb_i),
            .wb_pdest_i    (wb_pdest_i),
            .wb_data_i     (wb_data_i),
            .exe_valid_o   (exe_valid_o[b]),
            .exe_ready_i   (exe_ready_i[b]),
            .exe_base_o    (exe_base_o[b]),
            .exe_oc_o      (exe_oc_o[b]),
            .exe_src0_o    (exe_src0_o[b]),
            .exe_src1_o    (exe_src1_o[b])
        );
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: directed scenarios plus a randomized run against an
// in-order two-slot reference model with a coherent register file.
module tb_regfile_read_stage;
    import regfile_read_stage_pkg::*;

    localparam int NB = 2;
    localparam int DW = 32;

    logic                             clk = 1'b0;
    logic                             a_rst_n;
    logic                             flush_i;
    logic [NB-1:0]                    issue_valid;
    logic [NB-1:0]                    issue_ready;
    IssueBaseSt [NB-1:0]              issue_base;
    OptionCodeSt [NB-1:0]             issue_oc;
    logic [NB-1:0][1:0][PREG_AW-1:0]  rf_raddr;
    logic [NB-1:0][1:0][DW-1:0]       rf_rdata;
    logic [WB_WIDTH-1:0]              wb_v;
    logic [WB_WIDTH-1:0][PREG_AW-1:0] wb_pdest;
    logic [WB_WIDTH-1:0][DW-1:0]      wb_data;
    logic [NB-1:0]                    exe_valid;
    logic [NB-1:0]                    exe_ready;
    IssueBaseSt [NB-1:0]              exe_base;
    OptionCodeSt [NB-1:0]             exe_oc;
    logic [NB-1:0][DW-1:0]            exe_src0;
    logic [NB-1:0][DW-1:0]            exe_src1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_read_stage #(
        .BANK_NUM    (NB),
        .DATA_WIDTH  (DW),
        .OPTION_CODE (OptionCodeSt)
    ) u_dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_base_i  (issue_base),
        .issue_oc_i    (issue_oc),
        .rf_raddr_o    (rf_raddr),
        .rf_rdata_i    (rf_rdata),
        .wb_i          (wb_v),
        .wb_pdest_i    (wb_pdest),
        .wb_data_i     (wb_data),
        .exe_valid_o   (exe_valid),
        .exe_ready_i   (exe_ready),
        .exe_base_o    (exe_base),
        .exe_oc_o      (exe_oc),
        .exe_src0_o    (exe_src0),
        .exe_src1_o    (exe_src1)
    );

    // Register file stub: synchronous read, read-before-write, lowest wb port wins.
    logic [DW-1:0] rf_mem [PHY_REG_NUM];
    logic          rf_we = 1'b1;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            for (int n = 0; n < 2; n++)
                rf_rdata[b][n] <= rf_mem[rf_raddr[b][n]];
        if (rf_we)
            for (int k = WB_WIDTH - 1; k >= 0; k--)
                if (wb_v[k]) rf_mem[wb_pdest[k]] <= wb_data[k];
    end

    // Reference model: per lane an in-order list of at most two ops; an op's operands are
    // the architectural register values at the end of the cycle in which it leaves S1.
    typedef struct {
        IssueBaseSt  base;
        OptionCodeSt oc;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
        bit          cap;
    } op_t;
    op_t           slot [NB][2];
    int            cnt [NB];
    logic [DW-1:0] mrf [PHY_REG_NUM];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        issue_valid = '0;
        issue_base  = '0;
        issue_oc    = '0;
        wb_v        = '0;
        wb_pdest    = '0;
        wb_data     = '0;
        exe_ready   = '1;
    endtask

    function automatic IssueBaseSt mk_base(input logic [ROB_AW-1:0] rob,
                                           input logic v0, input logic [PREG_AW-1:0] p0,
                                           input logic v1, input logic [PREG_AW-1:0] p1);
        IssueBaseSt t;
        t.rob_idx     = rob;
        t.psrc0_valid = v0;
        t.psrc0       = p0;
        t.psrc1_valid = v1;
        t.psrc1       = p1;
        t.pdest_valid = 1'b0;
        t.pdest       = '0;
        return t;
    endfunction

    task automatic write_regs(input logic [PREG_AW-1:0] p0, input logic [DW-1:0] d0,
                              input logic [PREG_AW-1:0] p1, input logic [DW-1:0] d1);
        wb_v        = 2'b11;
        wb_pdest[0] = p0;
        wb_data[0]  = d0;
        wb_pdest[1] = p1;
        wb_data[1]  = d1;
        mrf[p1]     = d1;
        mrf[p0]     = d0;
        next_cycle();
        wb_v = '0;
    endtask

    task automatic test_reset();
        idle();
        a_rst_n = 1'b0;
        #2;
        checks++;
        if (exe_valid !== '0) begin
            failures++; $display("FAIL reset_exe_valid got=%b want=00", exe_valid);
        end
        checks++;
        if (rf_raddr !== '0) begin
            failures++; $display("FAIL reset_raddr got=%h want=0", rf_raddr);
        end
        checks++;
        if (exe_src0 !== '0 || exe_src1 !== '0) begin
            failures++; $display("FAIL reset_src got=%h/%h want=0", exe_src0, exe_src1);
        end
        checks++;
        if (issue_ready !== 2'b11) begin
            failures++; $display("FAIL reset_issue_ready got=%b want=11", issue_ready);
        end
        next_cycle();
        a_rst_n = 1'b1;
        next_cycle();
        for (int r = 0; r < 8; r += 2) write_regs(6'(r), '0, 6'(r + 1), '0);
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want0 [4];
        logic [DW-1:0] want1 [4];
        want0 = '{32'hAB, 32'hC0, 32'h0, 32'h0};
        want1 = '{32'h0, 32'h0, 32'h0, 32'h0};
        idle();
        rf_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            issue_valid[0] = 1'b1;
            if (t == 2) issue_base[0] = mk_base(5'(t), 1'b1, 6'd6, 1'b0, 6'd5);
            else        issue_base[0] = mk_base(5'(t), 1'b1, 6'd5, 1'b1, 6'd6);
            if (t == 3) begin
                // write-back coinciding with the accept itself is not snooped
                wb_v = 2'b01; wb_pdest[0] = 6'd5; wb_data[0] = 32'h77;
            end
            next_cycle();
            issue_valid = '0;
            wb_v = '0;
            if (t == 0) begin
                wb_v = 2'b10; wb_pdest[1] = 6'd5; wb_data[1] = 32'hAB;
            end else if (t == 1) begin
                wb_v = 2'b11; wb_pdest = {6'd5, 6'd5}; wb_data = {32'hD1, 32'hC0};
            end else if (t == 2) begin
                wb_v = 2'b01; wb_pdest[0] = 6'd5; wb_data[0] = 32'h55;
            end
            next_cycle();
            wb_v = '0;
            @(negedge clk);
            checks++;
            if (exe_valid[0] !== 1'b1 || exe_src0[0] !== want0[t] || exe_src1[0] !== want1[t]) begin
                failures++;
                $display("FAIL bypass_%0d got v=%b s0=%h s1=%h want v=1 s0=%h s1=%h",
                         t, exe_valid[0], exe_src0[0], exe_src1[0], want0[t], want1[t]);
            end
            next_cycle();
        end
        rf_we = 1'b1;
    endtask

    task automatic test_back_to_back();
        idle();
        write_regs(6'd5, 32'h11, 6'd7, 32'h22);
        for (int c = 0; c < 8; c++) begin
            issue_valid[0] = (c < 4);
            issue_base[0]  = mk_base(5'(c), 1'b1, 6'd5, 1'b1, 6'd7);
            @(negedge clk);
            checks++;
            if (issue_ready[0] !== 1'b1) begin
                failures++; $display("FAIL b2b_ready_c%0d got=%b want=1", c, issue_ready[0]);
            end
            checks++;
            if (c >= 2 && c < 6) begin
                if (exe_valid[0] !== 1'b1 || exe_base[0].rob_idx !== 5'(c - 2) ||
                    exe_src0[0] !== 32'h11 || exe_src1[0] !== 32'h22) begin
                    failures++;
                    $display("FAIL b2b_exe_c%0d got v=%b rob=%0d s0=%h s1=%h want v=1 rob=%0d s0=11 s1=22",
                             c, exe_valid[0], exe_base[0].rob_idx, exe_src0[0], exe_src1[0], c - 2);
                end
            end else if (exe_valid[0] !== 1'b0) begin
                failures++; $display("FAIL b2b_idle_c%0d got v=%b want v=0", c, exe_valid[0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int got [$];
        idle();
        exe_ready[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            issue_valid[0] = 1'b1;
            issue_base[0]  = mk_base(5'(c < 2 ? 10 + c : 12), 1'b1, 6'd5, 1'b1, 6'd7);
            if (c == 5) exe_ready[0] = 1'b1;
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                checks++;
                if (issue_ready[0] !== 1'b0 || exe_valid[0] !== 1'b1 ||
                    exe_base[0].rob_idx !== 5'd10 || exe_src0[0] !== 32'h11 ||
                    exe_src1[0] !== 32'h22) begin
                    failures++;
                    $display("FAIL stall_c%0d got rdy=%b v=%b rob=%0d s0=%h s1=%h want rdy=0 v=1 rob=10 s0=11 s1=22",
                             c, issue_ready[0], exe_valid[0], exe_base[0].rob_idx,
                             exe_src0[0], exe_src1[0]);
                end
            end
            if (c == 5) begin
                checks++;
                if (issue_ready[0] !== 1'b1) begin
                    failures++; $display("FAIL drain_accept got rdy=%b want=1", issue_ready[0]);
                end
            end
            if (exe_valid[0] && exe_ready[0]) got.push_back(int'(exe_base[0].rob_idx));
            next_cycle();
        end
        issue_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (exe_valid[0] && exe_ready[0]) got.push_back(int'(exe_base[0].rob_idx));
            next_cycle();
        end
        checks++;
        if (got.size() != 3 || got[0] != 10 || got[1] != 11 || got[2] != 12) begin
            failures++; $display("FAIL resume_order got=%p want=10,11,12", got);
        end
    endtask

    task automatic test_flush();
        bit seen;
        idle();
        exe_ready[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            issue_valid[0] = 1'b1;
            issue_base[0]  = mk_base(5'(20 + c), 1'b1, 6'd5, 1'b1, 6'd7);
            next_cycle();
        end
        flush_i       = 1'b1;
        issue_base[0] = mk_base(5'd30, 1'b1, 6'd5, 1'b1, 6'd7);
        @(negedge clk);
        checks++;
        if (issue_ready[0] !== 1'b0 || exe_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle got rdy=%b v=%b want rdy=0 v=0", issue_ready[0], exe_valid[0]);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (issue_ready[0] !== 1'b1 || exe_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL after_flush got rdy=%b v=%b want rdy=1 v=0", issue_ready[0], exe_valid[0]);
        end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (exe_valid[0]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL flush_leak got exe_valid pulse want none");
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        bit seen;
        idle();
        exe_ready[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            issue_valid[0] = 1'b1;
            issue_base[0]  = mk_base(5'(40 - 32 + c), 1'b1, 6'd5, 1'b1, 6'd7);
            next_cycle();
        end
        issue_valid = '0;
        @(negedge clk);
        checks++;
        if (exe_valid[0] !== 1'b1) begin
            failures++; $display("FAIL prereset_valid got=%b want=1", exe_valid[0]);
        end
        a_rst_n = 1'b0;
        #1;
        checks++;
        if (exe_valid !== '0 || exe_src0[0] !== '0 || exe_src1[0] !== '0) begin
            failures++;
            $display("FAIL async_reset got v=%b s0=%h s1=%h want v=00 s0=0 s1=0",
                     exe_valid, exe_src0[0], exe_src1[0]);
        end
        next_cycle();
        a_rst_n   = 1'b1;
        exe_ready = '1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (exe_valid !== '0 || issue_ready !== 2'b11) seen = 1'b1;
            next_cycle();
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL post_reset got spurious valid or stalled ready want idle");
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        idle();
        for (int r = 0; r < 8; r += 2) write_regs(6'(r), $urandom, 6'(r + 1), $urandom);
        for (int cyc = 0; cyc < 600; cyc++) begin
            flush_i = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < NB; b++) begin
                issue_valid[b] = ($urandom_range(0, 3) != 0);
                issue_base[b]  = mk_base(5'($urandom), $urandom_range(0, 3) != 0,
                                         6'($urandom_range(0, 7)),
                                         $urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)));
                issue_base[b].pdest_valid = 1'($urandom);
                issue_base[b].pdest       = 6'($urandom);
                issue_oc[b].op      = AluOpE'(3'($urandom_range(0, 7)));
                issue_oc[b].imm_sel = 1'($urandom);
                issue_oc[b].imm     = 12'($urandom);
                exe_ready[b]   = ($urandom_range(0, 2) != 0);
            end
            for (int k = 0; k < WB_WIDTH; k++) begin
                wb_v[k]     = 1'($urandom);
                wb_pdest[k] = 6'($urandom_range(0, 7));
                wb_data[k]  = $urandom;
            end
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                bit exp_rdy, exp_v;
                exp_rdy = (cnt[b] < 2 || exe_ready[b]) && !flush_i;
                exp_v   = cnt[b] > 0 && slot[b][0].cap && !flush_i;
                checks++;
                if (issue_ready[b] !== exp_rdy) begin
                    failures++;
                    $display("FAIL rnd_ready cyc=%0d lane=%0d got=%b want=%b", cyc, b, issue_ready[b], exp_rdy);
                end
                checks++;
                if (exe_valid[b] !== exp_v) begin
                    failures++;
                    $display("FAIL rnd_valid cyc=%0d lane=%0d got=%b want=%b", cyc, b, exe_valid[b], exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (exe_base[b] !== slot[b][0].base || exe_oc[b] !== slot[b][0].oc ||
                        exe_src0[b] !== slot[b][0].s0 || exe_src1[b] !== slot[b][0].s1) begin
                        failures++;
                        $display("FAIL rnd_payload cyc=%0d lane=%0d got base=%h oc=%h s0=%h s1=%h want base=%h oc=%h s0=%h s1=%h",
                                 cyc, b, exe_base[b], exe_oc[b], exe_src0[b], exe_src1[b],
                                 slot[b][0].base, slot[b][0].oc, slot[b][0].s0, slot[b][0].s1);
                    end
                end
                if (cnt[b] > 0 && !slot[b][cnt[b] - 1].cap) begin
                    IssueBaseSt s1b;
                    s1b = slot[b][cnt[b] - 1].base;
                    checks++;
                    if (rf_raddr[b][0] !== s1b.psrc0 || rf_raddr[b][1] !== s1b.psrc1) begin
                        failures++;
                        $display("FAIL rnd_raddr cyc=%0d lane=%0d got=%h/%h want=%h/%h",
                                 cyc, b, rf_raddr[b][0], rf_raddr[b][1], s1b.psrc0, s1b.psrc1);
                    end
                end
            end
            for (int k = WB_WIDTH - 1; k >= 0; k--)
                if (wb_v[k]) mrf[wb_pdest[k]] = wb_data[k];
            for (int b = 0; b < NB; b++) begin
                bit exp_rdy, fire;
                exp_rdy = (cnt[b] < 2 || exe_ready[b]) && !flush_i;
                fire    = cnt[b] > 0 && slot[b][0].cap && exe_ready[b];
                if (flush_i) begin
                    cnt[b] = 0;
                end else begin
                    if (fire) begin
                        slot[b][0] = slot[b][1];
                        cnt[b]--;
                    end
                    if (cnt[b] > 0 && !slot[b][0].cap) begin
                        slot[b][0].s0  = slot[b][0].base.psrc0_valid ? mrf[slot[b][0].base.psrc0] : '0;
                        slot[b][0].s1  = slot[b][0].base.psrc1_valid ? mrf[slot[b][0].base.psrc1] : '0;
                        slot[b][0].cap = 1'b1;
                    end
                    if (issue_valid[b] && exp_rdy) begin
                        slot[b][cnt[b]].base = issue_base[b];
                        slot[b][cnt[b]].oc   = issue_oc[b];
                        slot[b][cnt[b]].s0   = '0;
                        slot[b][cnt[b]].s1   = '0;
                        slot[b][cnt[b]].cap  = 1'b0;
                        cnt[b]++;
                    end
                end
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
